// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite mask type and latch state encoding
package sprite_pkg;
    localparam int NUM_SPRITES = 14;

    typedef logic [NUM_SPRITES-1:0] sprite_mask_t;

    typedef enum logic {
        S_IDLE,
        S_SHOW
    } state_t;
endpackage

// File: rtl/sprite_lowest_onehot.sv
// rtl/sprite_lowest_onehot.sv - isolates the lowest set bit of a sprite mask
module sprite_lowest_onehot
    import sprite_pkg::*;
(
    input  sprite_mask_t in_mask,
    output sprite_mask_t out_mask
);
    assign out_mask = in_mask & (~in_mask + sprite_mask_t'(1));
endmodule

// File: rtl/sprite_hit_latch.sv
// rtl/sprite_hit_latch.sv - holds one-hot drum sprites for HOLD_FRAMES frames; SPRITE_HIT_PENDING_EN enables queue mode
module sprite_hit_latch
    import sprite_pkg::*;
#(
    parameter int HOLD_FRAMES = 15,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SPRITES-1:0] hit,
    input  logic                   frame_tick,
    output logic [NUM_SPRITES-1:0] sprites,
    output logic                   busy
);
    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    sprite_mask_t      sprites_q, sprites_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    sprite_mask_t      sel_in, sel_out;
    logic              expire;

    assign expire = frame_tick && (cnt_q == ONE);

`ifdef SPRITE_HIT_PENDING_EN
    sprite_mask_t pending_q, pending_d, pending_next;

    // pending is always empty in IDLE, so this also serves the IDLE load
    assign pending_next = pending_q | hit;
    assign sel_in       = pending_next;
`else
    assign sel_in = hit;
`endif

    sprite_lowest_onehot u_lowest (
        .in_mask  (sel_in),
        .out_mask (sel_out)
    );

    always_comb begin
        state_d   = state_q;
        sprites_d = sprites_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
`ifdef SPRITE_HIT_PENDING_EN
        pending_d = pending_q;
`endif
        if (state_q == S_IDLE) begin
            if (|hit) begin
                state_d   = S_SHOW;
                sprites_d = sel_out;
                busy_d    = 1'b1;
                cnt_d     = HOLD;
`ifdef SPRITE_HIT_PENDING_EN
                pending_d = hit & ~sel_out;
`endif
            end
        end else begin
`ifdef SPRITE_HIT_PENDING_EN
            if (|(hit & sprites_q)) begin
                cnt_d     = HOLD;
                pending_d = pending_q | (hit & ~sprites_q);
            end else if (expire) begin
                if (|pending_next) begin
                    sprites_d = sel_out;
                    cnt_d     = HOLD;
                    pending_d = pending_next & ~sel_out;
                end else begin
                    state_d   = S_IDLE;
                    sprites_d = '0;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    pending_d = '0;
                end
            end else begin
                pending_d = pending_q | hit;
                if (frame_tick) cnt_d = cnt_q - ONE;
            end
`else
            if (|hit) begin
                sprites_d = sel_out;
                cnt_d     = HOLD;
            end else if (expire) begin
                state_d   = S_IDLE;
                sprites_d = '0;
                busy_d    = 1'b0;
                cnt_d     = '0;
            end else if (frame_tick) begin
                cnt_d = cnt_q - ONE;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sprites_q <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef SPRITE_HIT_PENDING_EN
            pending_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sprites_q <= sprites_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
`ifdef SPRITE_HIT_PENDING_EN
            pending_q <= pending_d;
`endif
        end
    end

    assign sprites = sprites_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_sprite_hit_latch.sv
// tb/tb_sprite_hit_latch.sv - scoreboard bench for sprite_hit_latch in preempt or queue build
module tb_sprite_hit_latch;
    logic        clk;
    logic        rst_n;
    logic [13:0] hit;
    logic        frame_tick;
    logic [13:0] sprites;
    logic        busy;

    logic [14:0] exp_q[$];
    logic [14:0] e;
    int          checks;
    int          passed;

    sprite_hit_latch #(.HOLD_FRAMES(15), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hit        (hit),
        .frame_tick (frame_tick),
        .sprites    (sprites),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle(input logic [13:0] h, input logic t,
                         input logic [13:0] es, input logic eb);
        hit        = h;
        frame_tick = t;
        exp_q.push_back({es, eb});
        @(posedge clk);
        #1;
        hit        = '0;
        frame_tick = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; hit = '0; frame_tick = 1'b0;
        #12;
        checks++;
        if ({sprites, busy} !== 15'h0) $display("FAIL reset: got sprites=%h busy=%b want 0000/0", sprites, busy);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        // tick in the load cycle must not count towards the hold
        cycle(14'h0004, 1'b1, 14'h0004, 1'b1);
        e = exp_q.pop_front(); checks++;
        if ({sprites, busy} !== e) $display("FAIL single_load: got %h/%b want %h/%b", sprites, busy, e[14:1], e[0]);
        else passed++;
        for (int i = 1; i <= 15; i++) begin
            cycle(14'h0, 1'b1, (i < 15) ? 14'h0004 : 14'h0, i < 15);
            e = exp_q.pop_front(); checks++;
            if ({sprites, busy} !== e) $display("FAIL single_tick%0d: got %h/%b want %h/%b", i, sprites, busy, e[14:1], e[0]);
            else passed++;
        end
        cycle(14'h0, 1'b1, 14'h0, 1'b0);
        e = exp_q.pop_front(); checks++;
        if ({sprites, busy} !== e) $display("FAIL idle_tick: got %h/%b want %h/%b", sprites, busy, e[14:1], e[0]);
        else passed++;
    endtask

    task automatic test_simultaneous;
        logic [13:0] after;
        cycle(14'h0A00, 1'b0, 14'h0200, 1'b1);
        e = exp_q.pop_front(); checks++;
        if ({sprites, busy} !== e) $display("FAIL simul_load: got %h/%b want %h/%b", sprites, busy, e[14:1], e[0]);
        else passed++;
`ifdef SPRITE_HIT_PENDING_EN
        after = 14'h0800;
`else
        after = 14'h0000;
`endif
        for (int i = 1; i <= 15; i++) begin
            cycle(14'h0, 1'b1, (i < 15) ? 14'h0200 : after, (i < 15) || (after != 0));
            e = exp_q.pop_front(); checks++;
            if ({sprites, busy} !== e) $display("FAIL simul_tick%0d: got %h/%b want %h/%b", i, sprites, busy, e[14:1], e[0]);
            else passed++;
        end
        if (after != 0) begin
            for (int i = 1; i <= 15; i++) begin
                cycle(14'h0, 1'b1, (i < 15) ? 14'h0800 : 14'h0, i < 15);
                e = exp_q.pop_front(); checks++;
                if ({sprites, busy} !== e) $display("FAIL simul_q_tick%0d: got %h/%b want %h/%b", i, sprites, busy, e[14:1], e[0]);
                else passed++;
            end
        end
    endtask

    task automatic test_retrigger;
        cycle(14'h0001, 1'b0, 14'h0001, 1'b1);
        e = exp_q.pop_front(); checks++;
        if ({sprites, busy} !== e) $display("FAIL retrig_load: got %h/%b want %h/%b", sprites, busy, e[14:1], e[0]);
        else passed++;
        for (int i = 1; i <= 10; i++) begin
            cycle(14'h0, 1'b1, 14'h0001, 1'b1);
            e = exp_q.pop_front(); checks++;
            if ({sprites, busy} !== e) $display("FAIL retrig_pre%0d: got %h/%b want %h/%b", i, sprites, busy, e[14:1], e[0]);
            else passed++;
        end
        cycle(14'h0001, 1'b0, 14'h0001, 1'b1);
        e = exp_q.pop_front(); checks++;
        if ({sprites, busy} !== e) $display("FAIL retrig_hit: got %h/%b want %h/%b", sprites, busy, e[14:1], e[0]);
        else passed++;
        for (int i = 1; i <= 15; i++) begin
            cycle(14'h0, 1'b1, (i < 15) ? 14'h0001 : 14'h0, i < 15);
            e = exp_q.pop_front(); checks++;
            if ({sprites, busy} !== e) $display("FAIL retrig_post%0d: got %h/%b want %h/%b", i, sprites, busy, e[14:1], e[0]);
            else passed++;
        end
    endtask

    task automatic test_collision;
        cycle(14'h0001, 1'b0, 14'h0001, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 1; i <= 14; i++) begin
            cycle(14'h0, 1'b1, 14'h0001, 1'b1);
            e = exp_q.pop_front(); checks++;
            if ({sprites, busy} !== e) $display("FAIL coll_pre%0d: got %h/%b want %h/%b", i, sprites, busy, e[14:1], e[0]);
            else passed++;
        end
        cycle(14'h2000, 1'b1, 14'h2000, 1'b1);
        e = exp_q.pop_front(); checks++;
        if ({sprites, busy} !== e) $display("FAIL coll_hit: got %h/%b want %h/%b", sprites, busy, e[14:1], e[0]);
        else passed++;
        // full reload: exactly 15 more ticks to expire
        for (int i = 1; i <= 15; i++) begin
            cycle(14'h0, 1'b1, (i < 15) ? 14'h2000 : 14'h0, i < 15);
            e = exp_q.pop_front(); checks++;
            if ({sprites, busy} !== e) $display("FAIL coll_post%0d: got %h/%b want %h/%b", i, sprites, busy, e[14:1], e[0]);
            else passed++;
        end
    endtask

    task automatic test_preempt_vs_queue;
        logic [13:0] first;
        logic [13:0] second;
        cycle(14'h0008, 1'b0, 14'h0008, 1'b1);
        void'(exp_q.pop_front());
`ifdef SPRITE_HIT_PENDING_EN
        first = 14'h0008; second = 14'h0010;
`else
        first = 14'h0010; second = 14'h0000;
`endif
        cycle(14'h0010, 1'b0, first, 1'b1);
        e = exp_q.pop_front(); checks++;
        if ({sprites, busy} !== e) $display("FAIL pvq_hit: got %h/%b want %h/%b", sprites, busy, e[14:1], e[0]);
        else passed++;
        for (int i = 1; i <= 15; i++) begin
            cycle(14'h0, 1'b1, (i < 15) ? first : second, (i < 15) || (second != 0));
            e = exp_q.pop_front(); checks++;
            if ({sprites, busy} !== e) $display("FAIL pvq_tick%0d: got %h/%b want %h/%b", i, sprites, busy, e[14:1], e[0]);
            else passed++;
        end
        if (second != 0) begin
            for (int i = 1; i <= 15; i++) begin
                cycle(14'h0, 1'b1, (i < 15) ? second : 14'h0, i < 15);
                e = exp_q.pop_front(); checks++;
                if ({sprites, busy} !== e) $display("FAIL pvq_q_tick%0d: got %h/%b want %h/%b", i, sprites, busy, e[14:1], e[0]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid;
        cycle(14'h0060, 1'b0, 14'h0020, 1'b1);
        e = exp_q.pop_front(); checks++;
        if ({sprites, busy} !== e) $display("FAIL mid_load: got %h/%b want %h/%b", sprites, busy, e[14:1], e[0]);
        else passed++;
        cycle(14'h0, 1'b1, 14'h0020, 1'b1);
        void'(exp_q.pop_front());
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sprites, busy} !== 15'h0) $display("FAIL mid_async: got %h/%b want 0000/0", sprites, busy);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(14'h0004, 1'b0, 14'h0004, 1'b1);
        e = exp_q.pop_front(); checks++;
        if ({sprites, busy} !== e) $display("FAIL mid_reload: got %h/%b want %h/%b", sprites, busy, e[14:1], e[0]);
        else passed++;
        // a leaked pending bit would surface here instead of going idle
        for (int i = 1; i <= 16; i++) begin
            cycle(14'h0, 1'b1, (i < 15) ? 14'h0004 : 14'h0, i < 15);
            e = exp_q.pop_front(); checks++;
            if ({sprites, busy} !== e) $display("FAIL mid_tick%0d: got %h/%b want %h/%b", i, sprites, busy, e[14:1], e[0]);
            else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_retrigger();
        test_collision();
        test_preempt_vs_queue();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sprite_hit_latch.md
# sprite_hit_latch

Converts raw per-drum hit pulses into the held, strictly one-hot 14-bit `sprites` vector consumed by `sprite_img_selector`. Each hit lights its sprite for a fixed number of video frames, counted on a frame tick. Simultaneous hits are arbitrated so the output is never multi-hot, because the downstream selector maps any multi-hot value to image 0. The block sits between the drum hit detectors and the sprite image selector in the graphics path.

## Interface
Parameters:
- `HOLD_FRAMES`, default 15: frames a sprite stays lit; legal range 1..255.
- `CNT_W`, default 8: frame counter width; must satisfy `HOLD_FRAMES < 2**CNT_W`.

Ports:
- `clk`, input, 1: single system clock; everything is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `hit`, input, 14: per-drum hit pulses, one cycle wide; bit i means drum i; several bits may be set at once.
- `frame_tick`, input, 1: one-cycle pulse per video frame (vsync edge).
- `sprites`, output, 14: registered; either one-hot or all zero.
- `busy`, output, 1: registered; high while any sprite is lit.

## Operation
- States:
  - IDLE: `sprites`=0, `busy`=0.
  - SHOW: one bit of `sprites` set, `busy`=1, `cnt` is 1..HOLD_FRAMES.
- Arbitration: when more than one candidate bit exists, the lowest index wins (bit 0 highest priority).
- IDLE to SHOW: on any nonzero `hit`, set `sprites` to the lowest set bit of `hit` and load `cnt` with HOLD_FRAMES. The other hit bits are discarded; see Configuration for the alternative.
- SHOW, no hit:
  - On `frame_tick` with `cnt`>1: decrement `cnt`.
  - On `frame_tick` with `cnt`==1: expire. Go to IDLE, or to the next pending sprite if that feature is compiled in.
- SHOW, re-hit of the currently lit bit: reload `cnt` to HOLD_FRAMES. `sprites` is unchanged.
- SHOW, hit on other bits (preempt mode): switch `sprites` to the lowest set bit of `hit` and reload `cnt`.
- Hit and expiring `frame_tick` in the same cycle: the hit wins. The new or retriggered sprite loads with a full HOLD_FRAMES, and no IDLE cycle appears.
- Arithmetic: `cnt` is unsigned CNT_W bits. It never decrements below 1 and never wraps.
- `frame_tick` in IDLE is ignored.

## Timing
- Reset: `sprites`=0, `busy`=0, `cnt`=0, pending mask=0, state IDLE. Reset is immediate and asynchronous. It may land mid-SHOW, and the block restarts clean afterwards.
- Latency: `hit` sampled at edge N gives `sprites` and `busy` valid after edge N+1 (one register stage).
- Expiry: the HOLD_FRAMES-th `frame_tick` after load, sampled at edge M, gives `sprites`=0 (or the next pending sprite) after edge M+1.
- The `frame_tick` in the load cycle itself does not count. The lit time is therefore exactly HOLD_FRAMES ticks after the load edge.
- Downstream, `sprite_img_selector` adds one further cycle. Hit to image index is 2 cycles.

## Configuration
- Macro: `SPRITE_HIT_PENDING_EN`.
- Undefined (default), preempt mode: a hit on a different drum during SHOW immediately replaces the lit sprite, as described in Operation.
- Defined, queue mode:
  - During SHOW, `hit` bits other than the lit bit are ORed into a 14-bit pending mask; the lit sprite is not replaced.
  - On expiry, take `pending_next` = pending | `hit`. If it is nonzero, load its lowest set bit, clear that bit from pending, reload `cnt`, and stay in SHOW with no gap cycle. Otherwise go to IDLE.
  - In IDLE, the extra bits of a multi-bit hit also go into pending.
  - Re-hits of bits already pending are absorbed, so each drum is queued at most once.

## Structure
- `sprite_pkg` holds:
  - `NUM_SPRITES`=14;
  - `typedef logic [NUM_SPRITES-1:0] sprite_mask_t`;
  - the state enum `{S_IDLE, S_SHOW}`.
- `sprite_img_selector` should adopt `sprite_mask_t` for its input.
- Sub-module `sprite_lowest_onehot`: combinational isolate of the lowest set bit, `out = in & (~in + 1)`. It is shared by the IDLE load and the pending dequeue.
- The top level holds the FSM, `cnt`, and the pending register (generated only under the macro).

## Test plan
- Reset, single hit: `rst_n` low then high; `hit`=14'h0004 → one edge later `sprites`=14'h0004, `busy`=1. Issue 15 `frame_tick`s → `sprites`=0 one edge after the 15th.
- Simultaneous hits: `hit`=14'h0A00 in IDLE → `sprites`=14'h0200. In preempt mode bit 11 is dropped. In queue mode, after 15 ticks `sprites`=14'h0800 with no zero cycle between.
- Retrigger: bit 0 lit, 10 ticks elapsed, `hit`=14'h0001 → `sprites` stays 14'h0001 and expires 15 ticks after the re-hit.
- Collision: `hit`=14'h2000 in the same cycle as the expiring tick of sprite 14'h0001 → `sprites`=14'h2000 with `cnt`=15 and `busy` never drops.
- Preempt vs queue: bit 3 lit, then `hit`=14'h0010 → preempt mode gives 14'h0010 next edge; queue mode keeps 14'h0008 until expiry, then gives 14'h0010.
- Reset mid-SHOW: `rst_n` asserted asynchronously between edges → `sprites`=0 and `busy`=0 immediately. After release, the pending mask is empty and a new hit behaves as in the first scenario.
